ps2_host_transmitter: RTL and testbench



---
 rtl/ps2_host_transmitter_if.sv | 26 ++
 rtl/ps2_host_transmitter.sv | 208 ++++++++++++++++++++
 tb/tb_ps2_host_transmitter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_transmitter_if.sv
// Core-side command handshake plus the shared PS/2 pin levels and open-drain enables.
// No logic; carries the byte request, the pin sense lines, the line controls and the status pulses.
// master = core/board side, slave = the transmitter.
interface ps2_host_transmitter_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clock_in;
  logic       ps2_data_in;
  logic       ps2_clock_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       done;
  logic       ack_error;
  logic       timeout;

  modport master (
    output tx_data, tx_valid, ps2_clock_in, ps2_data_in,
    input  tx_ready, ps2_clock_oe, ps2_data_oe, busy, done, ack_error, timeout
  );

  modport slave (
    input  tx_data, tx_valid, ps2_clock_in, ps2_data_in,
    output tx_ready, ps2_clock_oe, ps2_data_oe, busy, done, ack_error, timeout
  );
endinterface

// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device command sender: inhibit, start bit, 8 data + odd parity + stop, device ack check.
// Latency: clock held low INHIBIT_CYCLES after accept; data line follows each pin falling edge by 3 cycles.
// Backpressure: tx_ready only in IDLE; tx_valid outside IDLE is dropped, never queued.
module ps2_host_transmitter #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input logic                   clock,
  input logic                   reset_n,
  ps2_host_transmitter_if.slave bus
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_SEND,
    S_ACK,
    S_RELEASE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [1:0]       r_clk_sync;
  logic [1:0]       r_dat_sync;
  logic             r_clk_prev;
  logic             w_clk_s;
  logic             w_dat_s;
  logic             w_fall;

  // {stop, parity, d7..d0}; shifted right once per device falling edge
  logic [9:0]       r_frame;
  logic [9:0]       w_frame_nxt;
  logic [3:0]       r_bit;
  logic [3:0]       w_bit_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_ack_ok;
  logic             w_ack_ok_nxt;

  logic             r_clock_oe;
  logic             w_clock_oe_nxt;
  logic             r_data_oe;
  logic             w_data_oe_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             r_ack_err;
  logic             w_ack_err_nxt;
  logic             r_timeout;
  logic             w_timeout_nxt;

  logic             w_tx_ready;
  logic             w_tmo_hit;
  logic             w_abort;

  assign w_clk_s    = r_clk_sync[1];
  assign w_dat_s    = r_dat_sync[1];
  assign w_fall     = r_clk_prev & ~w_clk_s;
  assign w_tx_ready = (r_state == S_IDLE);
  assign w_tmo_hit  = (r_cnt == TMO_LAST);

  // Pin synchronizers and previous synced clock for falling-edge detection; idle lines read high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[0], bus.ps2_clock_in};
      r_dat_sync <= {r_dat_sync[0], bus.ps2_data_in};
      r_clk_prev <= w_clk_s;
    end
  end

  // State, datapath and registered line/pulse outputs; reset releases both lines immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_frame    <= '0;
      r_bit      <= '0;
      r_cnt      <= '0;
      r_ack_ok   <= 1'b0;
      r_clock_oe <= 1'b0;
      r_data_oe  <= 1'b0;
      r_done     <= 1'b0;
      r_ack_err  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_frame    <= w_frame_nxt;
      r_bit      <= w_bit_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ack_ok   <= w_ack_ok_nxt;
      r_clock_oe <= w_clock_oe_nxt;
      r_data_oe  <= w_data_oe_nxt;
      r_done     <= w_done_nxt;
      r_ack_err  <= w_ack_err_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  // Next-state and next-output decode; the cycle counter restarts on every state entry and device edge.
  always_comb begin
    w_state_nxt    = r_state;
    w_frame_nxt    = r_frame;
    w_bit_nxt      = r_bit;
    w_cnt_nxt      = r_cnt + 1'b1;
    w_ack_ok_nxt   = r_ack_ok;
    w_clock_oe_nxt = 1'b0;
    w_data_oe_nxt  = r_data_oe;
    w_done_nxt     = 1'b0;
    w_ack_err_nxt  = 1'b0;
    w_timeout_nxt  = 1'b0;
    w_abort        = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt     = '0;
        w_data_oe_nxt = 1'b0;
        if (bus.tx_valid && w_tx_ready) begin
          w_frame_nxt    = {1'b1, ~^bus.tx_data, bus.tx_data};
          w_bit_nxt      = '0;
          w_ack_ok_nxt   = 1'b0;
          w_clock_oe_nxt = 1'b1;
          w_state_nxt    = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        w_clock_oe_nxt = 1'b1;
        if (r_cnt == INH_LAST) begin
          w_data_oe_nxt = 1'b1;
          w_cnt_nxt     = '0;
          w_state_nxt   = S_START;
        end
      end
      S_START: begin
        // start bit stays driven low; clock is handed to the device
        w_data_oe_nxt = 1'b1;
        w_cnt_nxt     = '0;
        w_state_nxt   = S_SEND;
      end
      S_SEND: begin
        if (w_fall) begin
          w_cnt_nxt     = '0;
          w_data_oe_nxt = ~r_frame[0];
          w_frame_nxt   = {1'b0, r_frame[9:1]};
          w_bit_nxt     = r_bit + 1'b1;
          if (r_bit == 4'd9) begin
            w_state_nxt = S_ACK;
          end
        end else if (w_tmo_hit) begin
          w_abort = 1'b1;
        end
      end
      S_ACK: begin
        if (w_fall) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_RELEASE;
          if (!w_dat_s) begin
            w_ack_ok_nxt = 1'b1;
          end else begin
            w_ack_err_nxt = 1'b1;
          end
        end else if (w_tmo_hit) begin
          w_abort = 1'b1;
        end
      end
      S_RELEASE: begin
        if (w_clk_s && w_dat_s) begin
          w_cnt_nxt   = '0;
          w_done_nxt  = r_ack_ok;
          w_state_nxt = S_IDLE;
        end else if (w_tmo_hit) begin
          w_abort = 1'b1;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase

    // Abort releases both lines; after a failed ack the error already reported this frame,
    // so the timeout pulse is withheld to keep one outcome per byte.
    if (w_abort) begin
      w_state_nxt    = S_IDLE;
      w_cnt_nxt      = '0;
      w_clock_oe_nxt = 1'b0;
      w_data_oe_nxt  = 1'b0;
      w_timeout_nxt  = (r_state != S_RELEASE) || r_ack_ok;
    end
  end

  assign bus.tx_ready     = w_tx_ready;
  assign bus.busy         = ~w_tx_ready;
  assign bus.ps2_clock_oe = r_clock_oe;
  assign bus.ps2_data_oe  = r_data_oe;
  assign bus.done         = r_done;
  assign bus.ack_error    = r_ack_err;
  assign bus.timeout      = r_timeout;

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Bench for ps2_host_transmitter: open-drain line model, PS/2 device model, outcome scoreboard.
// Device clocks at 40 cycles/bit and reads each bit on the rising clock edge.
// Directed frames plus randomized bytes and ack decisions.
module tb_ps2_host_transmitter;

  localparam int INH  = 20;
  localparam int TMO  = 400;
  localparam int HALF = 20;

  localparam logic [2:0] OC_DONE = 3'b001;
  localparam logic [2:0] OC_AERR = 3'b010;
  localparam logic [2:0] OC_TMO  = 3'b100;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  logic dev_clk = 1'b1;
  logic dev_dat = 1'b1;

  int n_chk      = 0;
  int n_pass     = 0;
  int n_starts   = 0;
  int frames_exp = 0;
  logic [2:0] exp_q[$];
  logic [9:0] cap;

  always #5 clock = ~clock;

  ps2_host_transmitter_if bus();

  // open-drain wired-AND of host and device
  assign bus.ps2_clock_in = dev_clk & ~bus.ps2_clock_oe;
  assign bus.ps2_data_in  = dev_dat & ~bus.ps2_data_oe;

  ps2_host_transmitter #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Frame as the device sees it on the data line: d0..d7, odd parity, stop.
  function automatic logic [9:0] model_frame(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (d[i]) ones++;
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d};
  endfunction

  // Compare process: idle outputs every idle cycle, each status pulse against the expected outcome.
  initial begin
    logic prev_co;
    logic [2:0] obs;
    prev_co = 1'b0;
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (bus.tx_ready)
          check("idle_outputs", 32'({bus.busy, bus.ps2_clock_oe, bus.ps2_data_oe}), 32'(3'b000));
        obs = {bus.timeout, bus.ack_error, bus.done};
        if (obs != 3'b000) begin
          if (exp_q.size() == 0) check("unexpected_pulse", 32'(obs), 32'(3'b000));
          else check("outcome", 32'(obs), 32'(exp_q.pop_front()));
        end
        if (bus.ps2_clock_oe && !prev_co) n_starts++;
      end
      prev_co = bus.ps2_clock_oe;
    end
  end

  // Offer a byte when idle, then check the inhibit / start-bit / clock-release timeline.
  task automatic request(input logic [7:0] d);
    int n;
    int inh;
    n = 0;
    @(negedge clock);
    while (!bus.tx_ready && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check("req_ready", 32'(bus.tx_ready), 32'(1));
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge clock);
    bus.tx_valid = 1'b0;
    frames_exp++;
    check("ready_low_after_accept", 32'({bus.tx_ready, bus.busy}), 32'(2'b01));
    inh = 0;
    for (int k = 1; k <= INH; k++) begin
      if (bus.ps2_clock_oe && !bus.ps2_data_oe) inh++;
      @(negedge clock);
    end
    check("inhibit_cycles", 32'(inh), 32'(INH));
    check("start_bit", 32'({bus.ps2_clock_oe, bus.ps2_data_oe}), 32'(2'b11));
    @(negedge clock);
    check("clock_release", 32'({bus.ps2_clock_oe, bus.ps2_data_oe}), 32'(2'b01));
  endtask

  // Device: nbits clocks reading data at each rising edge, then optionally the ack clock.
  task automatic dev_clock(input int nbits, input bit do_ack, input bit ack_low, output logic [9:0] c);
    c = '0;
    for (int k = 0; k < nbits; k++) begin
      wait_cyc(HALF);
      dev_clk = 1'b0;
      wait_cyc(HALF);
      dev_clk = 1'b1;
      c[k] = bus.ps2_data_in;
    end
    if (do_ack) begin
      wait_cyc(HALF / 2);
      dev_dat = ack_low ? 1'b0 : 1'b1;
      wait_cyc(HALF / 2);
      dev_clk = 1'b0;
      wait_cyc(HALF);
      dev_clk = 1'b1;
      wait_cyc(HALF / 2);
      dev_dat = 1'b1;
    end
  endtask

  task automatic wait_closed();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !bus.tx_ready) && n < 1000) begin
      @(negedge clock);
      n++;
    end
    check("frame_closed", 32'(exp_q.size()), 32'(0));
    check("back_to_idle", 32'(bus.tx_ready), 32'(1));
  endtask

  task automatic run_frame(input logic [7:0] d, input bit ack_ok, input logic [9:0] exp_bits);
    logic [9:0] c;
    exp_q.push_back(ack_ok ? OC_DONE : OC_AERR);
    request(d);
    dev_clock(10, 1'b1, ack_ok, c);
    check($sformatf("frame_bits_%02h", d), 32'(c), 32'(exp_bits));
    wait_closed();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [7:0] rd;
    bit rok;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check("reset_state",
          32'({bus.tx_ready, bus.busy, bus.ps2_clock_oe, bus.ps2_data_oe, bus.done, bus.ack_error, bus.timeout}),
          32'(7'b1000000));
    wait_cyc(3);
    reset_n = 1'b1;

    check("model_pin_ED", 32'(model_frame(8'hED)), 32'(10'h3ED));
    check("model_pin_F4", 32'(model_frame(8'hF4)), 32'(10'h2F4));

    run_frame(8'hED, 1'b1, 10'h3ED);
    run_frame(8'h00, 1'b1, 10'h300);
    run_frame(8'hFF, 1'b1, 10'h3FF);
    run_frame(8'hF4, 1'b0, 10'h2F4);

    // device stops clocking after four bits
    exp_q.push_back(OC_TMO);
    request(8'hA5);
    dev_clock(4, 1'b0, 1'b0, cap);
    n = 0;
    while (!bus.timeout && n < 1000) begin
      @(negedge clock);
      n++;
    end
    check($sformatf("timeout_delay_%0d", n + HALF), 32'(n >= 380 && n <= 386), 32'(1));
    check("timeout_lines", 32'({bus.ps2_clock_oe, bus.ps2_data_oe, bus.tx_ready}), 32'(3'b001));
    wait_closed();

    // reset mid-frame while the host drives data low for d4 = 0
    request(8'h0F);
    dev_clock(4, 1'b0, 1'b0, cap);
    wait_cyc(HALF);
    dev_clk = 1'b0;
    wait_cyc(10);
    check("pre_reset_data_oe", 32'(bus.ps2_data_oe), 32'(1));
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_release",
          32'({bus.ps2_clock_oe, bus.ps2_data_oe, bus.busy, bus.tx_ready}), 32'(4'b0001));
    wait_cyc(5);
    dev_clk = 1'b1;
    wait_cyc(3);
    reset_n = 1'b1;

    // 0x55 with a stray request in flight
    exp_q.push_back(OC_DONE);
    request(8'h55);
    fork
      dev_clock(10, 1'b1, 1'b1, cap);
      begin
        wait_cyc(100);
        bus.tx_data  = 8'hAA;
        bus.tx_valid = 1'b1;
        wait_cyc(2);
        bus.tx_valid = 1'b0;
      end
    join
    check("frame_bits_55", 32'(cap), 32'(10'h355));
    wait_closed();

    for (int i = 0; i < 6; i++) begin
      rd  = 8'($urandom_range(255, 0));
      rok = 1'($urandom_range(1, 0));
      run_frame(rd, rok, model_frame(rd));
    end

    wait_cyc(60);
    check("frames_started", 32'(n_starts), 32'(frames_exp));
    check("no_pending_outcomes", 32'(exp_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
